// File: rtl/knn_host_if.sv
// Host register front end and stream FIFOs for the k-NN accelerator.
// Latency: reads return one cycle after rd_en; FIFO output is first-word fall-through.
// Backpressure: engine stalls a channel with m_ready; a host push into a full FIFO is dropped and flagged.

module knn_host_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       empty,
    output logic                       ovf,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr, rptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              full, do_pop, do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = wptr - rptr;
    assign do_pop  = pop && !empty;
    // A pop in the same edge frees the slot the push refills, so full does not block it.
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && full && !do_pop && !clear;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr[AW-1:0]] <= push_data;
    end
endmodule

module knn_host_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int NUM_CH     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int K_MAX      = 15,
    parameter int VLEN_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic [NUM_CH-1:0]            m_valid,
    input  logic [NUM_CH-1:0]            m_ready,
    output logic [NUM_CH*DATA_W-1:0]     m_data,
    output logic [$clog2(K_MAX+1)-1:0]   cfg_k,
    output logic [VLEN_W-1:0]            cfg_vlen,
    output logic                         eng_start,
    input  logic                         eng_busy,
    input  logic                         eng_done,
    output logic                         irq
);
    localparam int KW = $clog2(K_MAX+1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic              irq_en, done, err_start;
    logic [NUM_CH-1:0] err_ovf, ovf, empty, push_sel;
    logic [AW:0]       level [NUM_CH];
    logic              ctrl_wr, start_req, start_ok, fifo_clr, err_wr;
    logic [VLEN_W-1:0] vlen_new;
    logic [DATA_W-1:0] rd_mux;

    assign ctrl_wr   = wr_en && (wr_addr == ADDR_W'('h00));
    assign err_wr    = wr_en && (wr_addr == ADDR_W'('h04));
    assign start_req = ctrl_wr && wr_data[0];
    assign start_ok  = start_req && !eng_busy;
    assign fifo_clr  = ctrl_wr && wr_data[1];
    assign vlen_new  = wr_data[VLEN_W-1:0];
    assign irq       = done & irq_en;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push_sel[c] = wr_en && (wr_addr == ADDR_W'('h10 + c));
        assign m_valid[c]  = !empty[c];

        knn_host_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .clear     (fifo_clr),
            .push      (push_sel[c]),
            .push_data (wr_data),
            .pop       (m_ready[c]),
            .head      (m_data[c*DATA_W +: DATA_W]),
            .empty     (empty[c]),
            .ovf       (ovf[c]),
            .level     (level[c])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_k     <= KW'(1);
            cfg_vlen  <= VLEN_W'(1);
            irq_en    <= 1'b0;
            done      <= 1'b0;
            eng_start <= 1'b0;
            err_start <= 1'b0;
            err_ovf   <= '0;
        end else begin
            eng_start <= start_ok;
            if (ctrl_wr) irq_en <= wr_data[2];
            // A successful start clears done even if the engine reports completion that cycle.
            if (start_ok)      done <= 1'b0;
            else if (eng_done) done <= 1'b1;
            if (wr_en && wr_addr == ADDR_W'('h02)) begin
                if (wr_data == '0)                  cfg_k <= KW'(1);
                else if (wr_data > DATA_W'(K_MAX))  cfg_k <= KW'(K_MAX);
                else                                cfg_k <= wr_data[KW-1:0];
            end
            if (wr_en && wr_addr == ADDR_W'('h03))
                cfg_vlen <= (vlen_new == '0) ? VLEN_W'(1) : vlen_new;
            // New error events take priority over a same-cycle write-one-to-clear.
            err_start <= (err_start && !(err_wr && wr_data[0])) || (start_req && eng_busy);
            err_ovf   <= (err_ovf & ~(err_wr ? wr_data[8 +: NUM_CH] : '0)) | ovf;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            ADDR_W'('h00): rd_mux[2]   = irq_en;
            ADDR_W'('h01): rd_mux[1:0] = {done, eng_busy};
            ADDR_W'('h02): rd_mux      = DATA_W'(cfg_k);
            ADDR_W'('h03): rd_mux      = DATA_W'(cfg_vlen);
            ADDR_W'('h04): begin
                rd_mux[0]          = err_start;
                rd_mux[8 +: NUM_CH] = err_ovf;
            end
            default: ;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_addr == ADDR_W'('h20 + c)) rd_mux = DATA_W'(level[c]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rd_data <= '0;
        else if (rd_en) rd_data <= rd_mux;
    end
endmodule
